pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the Pong datapath. It owns the rally life-cycle: IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAMEOVER).
- Drives the ball block's run/recenter/speed/serve-direction controls and keeps both scores.
- Sits between the VGA timing generator (vblank), the ball/paddle collision logic (hit/miss pulses), the start button and the score display.

Parameters:
- SERVE_FRAMES, 60, frames the ball stays centred before launch (1..255)
- POINT_FRAMES, 90, frames of pause after a point (1..255)
- WIN_SCORE, 9, score that ends the game (1..15)
- SPEED_INIT, 2, ball speed at each serve (1..15)
- SPEED_MAX, 8, speed ceiling (SPEED_INIT..15)
- HITS_PER_STEP, 4, paddle hits per +1 speed step (1..15)

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-high reset
- vblank  in  1  vertical blank from VGA timing; may be asynchronous to clk
- start  in  1  debounced start button, level
- paddle_hit  in  1  one-clk pulse when the ball bounces off either paddle
- miss_left  in  1  one-clk pulse when the ball passes the left edge
- miss_right  in  1  one-clk pulse when the ball passes the right edge
- ball_run  out  1  ball may move on the frame update
- ball_center  out  1  hold the ball at its start position
- serve_dir  out  1  horizontal launch direction, `LEFT/`RIGHT encoding
- speed  out  4  ball speed, drives the ball speed input
- score_left  out  4  left player score
- score_right  out  4  right player score
- game_over  out  1  high in GAMEOVER
- winner  out  1  0 = left, 1 = right; valid while game_over

Behaviour:

Clock, reset and frame tick
- Single clock domain. rst is asynchronous assert and applies to all flops.
- Mid-operation reset returns every output and state to its reset value immediately.
- Reset values: state IDLE, ball_run 0, ball_center 1, serve_dir `RIGHT, speed SPEED_INIT, scores 0, game_over 0, winner 0, frame_cnt 0, hit_cnt 0.
- frame_tick is a one-clk pulse on the rising edge of vblank. vblank passes through a 2-FF synchroniser, then an edge detector, so frame_tick arrives 3 clk after the vblank edge.

State machine
- IDLE: ball_center=1, ball_run=0.
  - start=1 -> SERVE on the next clk.
  - On this transition: clear scores, speed=SPEED_INIT, serve_dir=`RIGHT, frame_cnt=0.
- SERVE: ball_center=1, ball_run=0.
  - frame_cnt increments on each frame_tick.
  - The tick that makes frame_cnt reach SERVE_FRAMES -> PLAY; frame_cnt cleared.
  - PLAY outputs (ball_center=0, ball_run=1) are registered, visible 1 clk after that tick.
- PLAY: ball_run=1, ball_center=0.
  - paddle_hit increments hit_cnt. When hit_cnt reaches HITS_PER_STEP, clear it and set speed=min(speed+1, SPEED_MAX). speed saturates at SPEED_MAX and never wraps.
  - miss_left: score_right+1, serve_dir=`LEFT, -> POINT.
  - miss_right: score_left+1, serve_dir=`RIGHT, -> POINT.
  - miss_left and miss_right in the same clk: only miss_left is processed.
  - paddle_hit together with a miss in the same clk: the miss wins and the hit is dropped.
- POINT: ball_run=0, ball_center=0 (ball frozen where it left).
  - frame_cnt counts frame_ticks up to POINT_FRAMES.
  - Then, if either score equals WIN_SCORE -> GAMEOVER, with winner set to the side that reached it.
  - Otherwise -> SERVE, with speed=SPEED_INIT and hit_cnt=0.
- GAMEOVER: game_over=1, ball_run=0, ball_center=1.
  - start=1 -> SERVE with the same initialisation as IDLE -> SERVE.

Input filtering
- paddle_hit, miss_* outside PLAY are ignored.
- start outside IDLE/GAMEOVER is ignored.
- A start held high through GAMEOVER restarts at once; no edge requirement.

Width and timing rules
- Scores are 4 bit and saturate at 15. This is unreachable with legal WIN_SCORE.
- frame_cnt is 8 bit. hit_cnt is 4 bit.
- All outputs are registered.
- speed changes only in clk cycles. The ball block samples it per frame, so a mid-frame update is legal.

Decomposition:
- Constants in the shared defs.v include:
  - state encodings GS_IDLE/GS_SERVE/GS_PLAY/GS_POINT/GS_GAMEOVER (3 bit)
  - the existing `LEFT/`RIGHT direction codes
- Sub-module frame_tick_gen (vblank 2-FF sync + rising-edge pulse). It is reusable by paddle logic.
- The FSM and counters stay in pong_game_ctrl.

Test Plan:
- Reset/start: rst pulse, then start=1 for 1 clk with SERVE_FRAMES=3 -> ball_center=1, ball_run=0 for 3 vblank rises. ball_run rises 1 clk after the 3rd frame_tick. speed=2, serve_dir=`RIGHT.
- Speed ramp: in PLAY, 4 paddle_hit pulses -> speed 2->3. After 24 more hits -> speed 8 and holds at 8 on the next 4 hits.
- Scoring and serve: miss_right in PLAY -> score_left=1, serve_dir=`RIGHT, ball_run=0. After POINT_FRAMES=2 ticks -> SERVE, speed back to 2.
- Simultaneous events: miss_left, miss_right and paddle_hit in the same clk -> score_right=1 only, score_left=0, speed/hit count unchanged.
- Game over: WIN_SCORE=3, three miss_left points -> GAMEOVER, game_over=1, winner=1, score_right=3. A further miss pulse leaves scores unchanged. start -> scores 0, state SERVE.
- Reset mid-rally: assert rst during PLAY at speed 5, scores 2/1 -> all outputs at reset values in the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong game sequencer: game states, serve
// direction codes and a small saturating-increment helper.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    GS_SERVE    = 3'd1,
    GS_PLAY     = 3'd2,
    GS_POINT    = 3'd3,
    GS_GAMEOVER = 3'd4
  } game_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_tick_gen.sv
// Turns the (possibly asynchronous) vblank into a one-clk frame_tick:
// 2-FF synchroniser followed by a registered rising-edge detector.
module pong_game_ctrl_frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblank,
  output logic frame_tick
);

  logic sync_meta;
  logic sync_stable;
  logic sync_prev;

  // The pulse is registered so it lands 3 clk after the vblank edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      sync_stable <= 1'b0;
      sync_prev   <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      sync_meta   <= vblank;
      sync_stable <= sync_meta;
      sync_prev   <= sync_stable;
      frame_tick  <= sync_stable & ~sync_prev;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns the rally life-cycle, drives the ball controls
// (run / recenter / speed / serve direction) and keeps both scores.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned POINT_FRAMES  = 90,
  parameter int unsigned WIN_SCORE     = 9,
  parameter int unsigned SPEED_INIT    = 2,
  parameter int unsigned SPEED_MAX     = 8,
  parameter int unsigned HITS_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic       start,
  input  logic       paddle_hit,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] speed,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner
);

  game_state_t state, state_next;
  logic        frame_tick;
  logic [7:0]  frame_cnt;
  logic [3:0]  hit_cnt;
  logic        serve_done, point_done, win_reached, miss_any;
  logic        run_next, center_next, over_next;

  pong_game_ctrl_frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .vblank     (vblank),
    .frame_tick (frame_tick)
  );

  assign serve_done  = frame_tick && ((frame_cnt + 8'd1) == 8'(SERVE_FRAMES));
  assign point_done  = frame_tick && ((frame_cnt + 8'd1) == 8'(POINT_FRAMES));
  assign win_reached = (score_left == 4'(WIN_SCORE)) || (score_right == 4'(WIN_SCORE));
  assign miss_any    = miss_left | miss_right;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GS_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      GS_IDLE:     if (start)      state_next = GS_SERVE;
      GS_SERVE:    if (serve_done) state_next = GS_PLAY;
      GS_PLAY:     if (miss_any)   state_next = GS_POINT;
      GS_POINT:    if (point_done) state_next = win_reached ? GS_GAMEOVER : GS_SERVE;
      GS_GAMEOVER: if (start)      state_next = GS_SERVE;
      default:                     state_next = GS_IDLE;
    endcase
  end

  // Decoded from the next state so the registered outputs track the state register.
  always_comb begin
    run_next    = 1'b0;
    center_next = 1'b1;
    over_next   = 1'b0;
    case (state_next)
      GS_PLAY: begin
        run_next    = 1'b1;
        center_next = 1'b0;
      end
      GS_POINT:    center_next = 1'b0;
      GS_GAMEOVER: over_next   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_run    <= 1'b0;
      ball_center <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      ball_run    <= run_next;
      ball_center <= center_next;
      game_over   <= over_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_dir   <= DIR_RIGHT;
      speed       <= 4'(SPEED_INIT);
      score_left  <= 4'd0;
      score_right <= 4'd0;
      winner      <= 1'b0;
      frame_cnt   <= 8'd0;
      hit_cnt     <= 4'd0;
    end else begin
      case (state)
        GS_IDLE, GS_GAMEOVER: begin
          if (start) begin
            serve_dir   <= DIR_RIGHT;
            speed       <= 4'(SPEED_INIT);
            score_left  <= 4'd0;
            score_right <= 4'd0;
            frame_cnt   <= 8'd0;
            hit_cnt     <= 4'd0;
          end
        end
        GS_SERVE: begin
          if (serve_done)      frame_cnt <= 8'd0;
          else if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
        end
        GS_PLAY: begin
          // miss_left has priority over miss_right; any miss drops a coincident hit.
          if (miss_left) begin
            score_right <= sat_inc4(score_right);
            serve_dir   <= DIR_LEFT;
            frame_cnt   <= 8'd0;
          end else if (miss_right) begin
            score_left <= sat_inc4(score_left);
            serve_dir  <= DIR_RIGHT;
            frame_cnt  <= 8'd0;
          end else if (paddle_hit) begin
            if ((hit_cnt + 4'd1) == 4'(HITS_PER_STEP)) begin
              hit_cnt <= 4'd0;
              speed   <= (speed >= 4'(SPEED_MAX)) ? speed : speed + 4'd1;
            end else begin
              hit_cnt <= hit_cnt + 4'd1;
            end
          end
        end
        GS_POINT: begin
          if (point_done) begin
            frame_cnt <= 8'd0;
            if (win_reached) begin
              winner <= (score_right == 4'(WIN_SCORE));
            end else begin
              speed   <= 4'(SPEED_INIT);
              hit_cnt <= 4'd0;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with short frame counts
// (SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=3).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblank;
  logic       start;
  logic       paddle_hit;
  logic       miss_left;
  logic       miss_right;
  logic       ball_run;
  logic       ball_center;
  logic       serve_dir;
  logic [3:0] speed;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl #(
    .SERVE_FRAMES  (3),
    .POINT_FRAMES  (2),
    .WIN_SCORE     (3),
    .SPEED_INIT    (2),
    .SPEED_MAX     (8),
    .HITS_PER_STEP (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vblank      (vblank),
    .start       (start),
    .paddle_hit  (paddle_hit),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .ball_run    (ball_run),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .speed       (speed),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One-clk pulse on the event inputs, then one idle clk.
  task automatic apply_stimulus(input logic hit, input logic ml, input logic mr);
    paddle_hit = hit;
    miss_left  = ml;
    miss_right = mr;
    @(negedge clk);
    paddle_hit = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic tick_frame();
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) tick_frame();
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_run"},    ball_run,    0);
    check_output({tag, "_center"}, ball_center, 1);
    check_output({tag, "_dir"},    serve_dir,   1);
    check_output({tag, "_speed"},  speed,       2);
    check_output({tag, "_sl"},     score_left,  0);
    check_output({tag, "_sr"},     score_right, 0);
    check_output({tag, "_over"},   game_over,   0);
    check_output({tag, "_winner"}, winner,      0);
  endtask

  initial begin
    rst = 1'b1; vblank = 1'b0; start = 1'b0;
    paddle_hit = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);

    // Start and serve countdown
    press_start();
    check_output("serve_center", ball_center, 1);
    check_output("serve_run", ball_run, 0);
    tick_frame();
    check_output("serve_tick1_run", ball_run, 0);
    tick_frame();
    check_output("serve_tick2_run", ball_run, 0);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    check_output("tick3_same_clk_run", ball_run, 0);
    @(negedge clk);
    check_output("play_run", ball_run, 1);
    check_output("play_center", ball_center, 0);
    check_output("play_speed", speed, 2);
    check_output("play_dir", serve_dir, 1);
    vblank = 1'b0;
    repeat (4) @(negedge clk);

    // Speed ramp and saturation
    hits(3);
    check_output("ramp_3hits", speed, 2);
    hits(1);
    check_output("ramp_4hits", speed, 3);
    hits(24);
    check_output("ramp_28hits", speed, 8);
    hits(4);
    check_output("ramp_sat", speed, 8);

    // Point for left
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("mr_sl", score_left, 1);
    check_output("mr_sr", score_right, 0);
    check_output("mr_dir", serve_dir, 1);
    check_output("mr_run", ball_run, 0);
    check_output("mr_center", ball_center, 0);
    check_output("mr_speed_held", speed, 8);
    tick_frame();
    check_output("point_tick1_center", ball_center, 0);
    tick_frame();
    check_output("point_done_center", ball_center, 1);
    check_output("point_done_run", ball_run, 0);
    check_output("point_done_speed", speed, 2);

    // Simultaneous miss_left / miss_right / paddle_hit
    frames(3);
    check_output("rally2_run", ball_run, 1);
    hits(3);
    check_output("rally2_speed", speed, 2);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("sim_sr", score_right, 1);
    check_output("sim_sl", score_left, 1);
    check_output("sim_speed", speed, 2);
    check_output("sim_dir", serve_dir, 0);
    check_output("sim_run", ball_run, 0);

    // Right player reaches WIN_SCORE
    frames(2);
    frames(3);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("ml2_sr", score_right, 2);
    frames(2);
    check_output("ml2_over", game_over, 0);
    check_output("ml2_center", ball_center, 1);
    frames(3);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("ml3_sr", score_right, 3);
    tick_frame();
    check_output("ml3_tick1_over", game_over, 0);
    tick_frame();
    check_output("go_over", game_over, 1);
    check_output("go_winner", winner, 1);
    check_output("go_sr", score_right, 3);
    check_output("go_center", ball_center, 1);
    check_output("go_run", ball_run, 0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("go_ignore_sr", score_right, 3);
    check_output("go_ignore_sl", score_left, 1);
    check_output("go_ignore_over", game_over, 1);
    press_start();
    check_output("restart_sl", score_left, 0);
    check_output("restart_sr", score_right, 0);
    check_output("restart_over", game_over, 0);
    check_output("restart_center", ball_center, 1);
    check_output("restart_speed", speed, 2);
    check_output("restart_dir", serve_dir, 1);

    // Build scores 2/1 and speed 5, then reset mid-rally
    frames(3);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    frames(2); frames(3);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    frames(2); frames(3);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    frames(2); frames(3);
    hits(12);
    check_output("mid_speed", speed, 5);
    check_output("mid_sl", score_left, 2);
    check_output("mid_sr", score_right, 1);
    check_output("mid_run", ball_run, 1);
    check_output("mid_dir", serve_dir, 0);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
